// File: rtl/ppe_pkg.sv
// ppe_pkg
// Shared definitions for the 512-wide circular priority encoder.
//   WIDTH     : request vector width
//   IDX_W     : index width, log2(WIDTH)
//   NUM_SEGS  : number of segments each priority encoder is split into
//   idx_t     : request index type
package ppe_pkg;
    localparam int WIDTH    = 512;
    localparam int IDX_W    = 9;
    localparam int NUM_SEGS = 8;

    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/ppe_w512_p_simple_pe.sv
// simple_pe
// Lowest-set-bit priority encoder, split into NUM_SEGS equal segments.
// Each segment is encoded in parallel and the results are registered; a
// combinational segment-select stage then picks the lowest non-empty segment.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-low reset, clears the segment registers
//   vec    : W-bit input vector
//   index  : index of the lowest set bit (0 when none), one cycle after vec
//   any    : high when vec had at least one bit set, one cycle after vec
module simple_pe
    import ppe_pkg::*;
#(
    parameter int W    = 512,
    parameter int SEGS = NUM_SEGS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         vec,
    output logic [$clog2(W)-1:0] index,
    output logic                 any
);
    localparam int SEG_W  = W / SEGS;
    localparam int SEG_IW = $clog2(SEG_W);
    localparam int SEL_W  = $clog2(SEGS);
    localparam int IW     = $clog2(W);

    logic [SEG_IW-1:0] seg_idx_next [SEGS];
    logic [SEG_IW-1:0] seg_idx_reg  [SEGS];
    logic [SEGS-1:0]   seg_any_next;
    logic [SEGS-1:0]   seg_any_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SEGS; gi++) begin : g_seg
            // Scan downward so the last hit written is the lowest set bit.
            always_comb begin
                seg_idx_next[gi] = '0;
                for (int b = SEG_W - 1; b >= 0; b--) begin
                    if (vec[gi*SEG_W + b]) begin
                        seg_idx_next[gi] = SEG_IW'(b);
                    end
                end
            end

            assign seg_any_next[gi] = |vec[gi*SEG_W +: SEG_W];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    seg_idx_reg[gi] <= '0;
                    seg_any_reg[gi] <= 1'b0;
                end else begin
                    seg_idx_reg[gi] <= seg_idx_next[gi];
                    seg_any_reg[gi] <= seg_any_next[gi];
                end
            end
        end
    endgenerate

    // Segment select: lowest non-empty segment supplies the upper index bits.
    always_comb begin
        index = '0;
        for (int s = SEGS - 1; s >= 0; s--) begin
            if (seg_any_reg[s]) begin
                index = IW'({SEL_W'(s), seg_idx_reg[s]});
            end
        end
    end

    assign any = |seg_any_reg;
endmodule

// File: rtl/ppe_w512_p.sv
// ppe_w512_p
// Circular (round-robin style) priority encoder over a 512-bit request
// vector. Grants the lowest set index at or above P_enc, wrapping to the
// lowest set index overall when nothing is set at or above it.
// Two-stage pipeline, one result per cycle:
//   stage 1 : mask generation and per-segment encodes (inside simple_pe)
//   stage 2 : masked/unmasked select, increment and valid
// Ports:
//   clk         : clock
//   rst         : asynchronous active-low reset
//   Req         : request bitmap
//   P_enc       : index holding highest priority
//   o_value     : granted index (0 when no request)
//   o_value_inc : (o_value + 1) mod WIDTH (0 when no request)
//   valid       : at least one request bit was set
module ppe_w512_p #(
    parameter int WIDTH = ppe_pkg::WIDTH,
    parameter int IDX_W = ppe_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Req,
    input  logic [IDX_W-1:0] P_enc,
    output logic [IDX_W-1:0] o_value,
    output logic [IDX_W-1:0] o_value_inc,
    output logic             valid
);
    import ppe_pkg::*;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] req_masked;
    idx_t             masked_idx;
    idx_t             unmasked_idx;
    logic             masked_any;
    logic             unmasked_any;

    logic [IDX_W-1:0] value_next;
    logic [IDX_W-1:0] value_inc_next;
    logic [IDX_W-1:0] value_reg;
    logic [IDX_W-1:0] value_inc_reg;
    logic             valid_reg;

    // Keep only requests at indices >= P_enc.
    assign mask       = {WIDTH{1'b1}} << P_enc;
    assign req_masked = Req & mask;

    simple_pe #(.W(WIDTH)) u_pe_masked (
        .clk   (clk),
        .rst   (rst),
        .vec   (req_masked),
        .index (masked_idx),
        .any   (masked_any)
    );

    simple_pe #(.W(WIDTH)) u_pe_unmasked (
        .clk   (clk),
        .rst   (rst),
        .vec   (Req),
        .index (unmasked_idx),
        .any   (unmasked_any)
    );

    // Masked hit wins; otherwise wrap to the lowest request overall. The
    // unmasked encoder's "any" doubles as valid since it sees every bit.
    always_comb begin
        value_next     = '0;
        value_inc_next = '0;
        if (unmasked_any) begin
            value_next     = masked_any ? masked_idx : unmasked_idx;
            value_inc_next = value_next + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_reg     <= '0;
            value_inc_reg <= '0;
            valid_reg     <= 1'b0;
        end else begin
            value_reg     <= value_next;
            value_inc_reg <= value_inc_next;
            valid_reg     <= unmasked_any;
        end
    end

    assign o_value     = value_reg;
    assign o_value_inc = value_inc_reg;
    assign valid       = valid_reg;
endmodule

// File: tb/tb_ppe_w512_p.sv
module tb_ppe_w512_p;
    localparam int W  = 512;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  Req = '0;
    logic [IW-1:0] P_enc = '0;
    logic [IW-1:0] o_value;
    logic [IW-1:0] o_value_inc;
    logic          valid;

    int n_checks = 0;
    int n_pass   = 0;

    ppe_w512_p dut (
        .clk         (clk),
        .rst         (rst),
        .Req         (Req),
        .P_enc       (P_enc),
        .o_value     (o_value),
        .o_value_inc (o_value_inc),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  req;
        logic [IW-1:0] p;
        logic [IW-1:0] ev;
        logic [IW-1:0] ei;
        logic          evld;
    } vec_t;

    typedef struct {
        logic [IW-1:0] ev;
        logic [IW-1:0] ei;
        logic          evld;
    } exp_t;

    vec_t tbl[9];
    exp_t exp_q[$];

    // Reference: walk the ring starting at p, first requester found wins.
    function automatic exp_t model(input logic [W-1:0] r, input int p);
        exp_t e;
        e.ev = '0; e.ei = '0; e.evld = 1'b0;
        for (int k = 0; k < W; k++) begin
            int j;
            j = (p + k) % W;
            if (r[j]) begin
                e.evld = 1'b1;
                e.ev   = IW'(j);
                e.ei   = IW'((j + 1) % W);
                break;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [IW-1:0] ev,
                         input logic [IW-1:0] ei, input logic evld);
        n_checks++;
        if (o_value === ev && o_value_inc === ei && valid === evld) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got value=%0d inc=%0d valid=%0b, expected value=%0d inc=%0d valid=%0b",
                     name, o_value, o_value_inc, valid, ev, ei, evld);
        end
    endtask

    function automatic logic [W-1:0] low7(input logic [6:0] b);
        logic [W-1:0] r;
        r = '0;
        r[6:0] = b;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_req();
        logic [W-1:0] r;
        int mode;
        r = '0;
        mode = $urandom_range(0, 3);
        if (mode == 0) begin
            for (int w = 0; w < W / 32; w++) r[w*32 +: 32] = $urandom;
        end else if (mode == 1 || mode == 2) begin
            for (int k = 0; k < mode; k++) r[$urandom_range(0, W-1)] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        tbl[0] = '{low7(7'b0100101), 9'd5,   9'd5,   9'd6,   1'b1};
        tbl[1] = '{low7(7'b0101101), 9'd4,   9'd5,   9'd6,   1'b1};
        tbl[2] = '{low7(7'b0100111), 9'd2,   9'd2,   9'd3,   1'b1};
        tbl[3] = '{low7(7'b1100101), 9'd1,   9'd2,   9'd3,   1'b1};
        tbl[4] = '{low7(7'b1010101), 9'd0,   9'd0,   9'd1,   1'b1};
        tbl[5] = '{low7(7'b0100101), 9'd6,   9'd0,   9'd1,   1'b1};
        tbl[6] = '{'0,               9'd4,   9'd0,   9'd0,   1'b0};
        tbl[7] = '{{W{1'b1}},        9'd500, 9'd500, 9'd501, 1'b1};
        tbl[8] = '{{W{1'b1}},        9'd511, 9'd511, 9'd0,   1'b1};

        // Reset state, with live requests on the inputs.
        Req = {W{1'b1}}; P_enc = 9'd3;
        repeat (3) @(posedge clk);
        #1 check("reset_state", '0, '0, 1'b0);

        @(negedge clk) rst = 1'b1;

        // Directed table, one vector at a time, 2 edges of latency.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            Req = tbl[i].req; P_enc = tbl[i].p;
            @(posedge clk);
            @(posedge clk);
            #1 check($sformatf("table_%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].evld);
        end

        // Extra boundary: all ones at 503.
        @(negedge clk);
        Req = {W{1'b1}}; P_enc = 9'd503;
        repeat (2) @(posedge clk);
        #1 check("all_ones_503", 9'd503, 9'd504, 1'b1);

        // Back-to-back table: output after each edge is the vector from the
        // previous cycle's drive (two-stage pipeline).
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i < 9) begin Req = tbl[i].req; P_enc = tbl[i].p; end
            @(posedge clk);
            #1;
            if (i >= 1)
                check($sformatf("b2b_%0d", i-1), tbl[i-1].ev, tbl[i-1].ei, tbl[i-1].evld);
        end

        // Randomized stream against the ring-walk model.
        exp_q.delete();
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (i < 300) begin
                Req = rand_req();
                P_enc = IW'($urandom_range(0, W-1));
                exp_q.push_back(model(Req, int'(P_enc)));
            end
            @(posedge clk);
            #1;
            if (i >= 1) begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rand_%0d", i-1), e.ev, e.ei, e.evld);
            end
        end

        // Mid-stream reset: outputs clear immediately, in-flight data dropped.
        @(negedge clk);
        Req = low7(7'b0100101); P_enc = 9'd5;
        @(posedge clk);
        @(negedge clk);
        Req = low7(7'b1100101); P_enc = 9'd1;
        @(posedge clk);
        #1 check("pre_reset", 9'd5, 9'd6, 1'b1);
        #2 rst = 1'b0;
        #1 check("async_reset_clear", '0, '0, 1'b0);
        @(posedge clk);
        #1 check("reset_held", '0, '0, 1'b0);

        // Release: first edge with rst high samples the new vector.
        @(negedge clk);
        rst = 1'b1;
        Req = low7(7'b0100111); P_enc = 9'd2;
        @(posedge clk);
        #1 check("post_reset_flushed", '0, '0, 1'b0);
        @(posedge clk);
        #1 check("post_reset_first", 9'd2, 9'd3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ppe_w512_p.md
PPE_W512_P -- requirements
Module: ppe_w512_p

Interface
REQ-001 Parameter WIDTH, default 512: request vector width; fixed at 512 for this block.
REQ-002 Parameter IDX_W, default 9: index width, equal to log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset: asserts immediately when low, deasserts synchronously to clk.
REQ-005 Req  input  512  request bitmap; bit i set = requester i is active.
REQ-006 P_enc  input  9  priority pointer: index holding highest priority.
REQ-007 o_value  output  9  index of the granted request.
REQ-008 o_value_inc  output  9  (o_value + 1) mod 512.
REQ-009 valid  output  1  high when at least one Req bit was set.

Function
REQ-010 The block SHALL grant the lowest set index i with i >= P_enc (inclusive, circular search upward).
REQ-011 If no set bit exists at or above P_enc, the block SHALL grant the lowest set index overall (wrap-around).
REQ-012 valid SHALL equal OR-reduction of the sampled Req.
REQ-013 When valid is 0, o_value and o_value_inc SHALL both be 0.
REQ-014 o_value_inc SHALL wrap modulo 512, so grant 511 gives 0.
REQ-015 Inputs SHALL be sampled every cycle; outputs SHALL be registered.
REQ-016 Latency SHALL be exactly 2 clk cycles from input sample to outputs; throughput is one result per cycle, with no handshake or stall.
REQ-017 Req/P_enc changing every cycle SHALL yield independent results, each 2 cycles later, in order.
REQ-018 P_enc = 0 SHALL behave as a plain lowest-index priority encoder.
REQ-019 P_enc = 511 SHALL grant 511 if Req[511] is set, else the lowest set index.
REQ-020 The search SHALL be implemented as two parallel priority encodes: Req masked to indices >= P_enc, and unmasked Req. The masked result wins if nonzero.

Reset
REQ-021 While rst is low, o_value = 0, o_value_inc = 0 and valid = 0, and all pipeline registers SHALL clear.
REQ-022 Reset asserted mid-operation SHALL discard in-flight results.
REQ-023 After reset release, the first valid output SHALL reflect inputs sampled on the first rising edge with rst high, appearing 2 cycles later.

Structure
REQ-024 WIDTH and IDX_W SHALL be defined in a shared package (ppe_pkg) together with an index typedef.
REQ-025 A single sub-module, simple_pe, SHALL form a lowest-set-bit priority encoder with outputs index and any.
- Width is parameterised; instantiated twice (masked and unmasked).
- Internally built as 8 x 64-bit segments with a segment-select stage.
REQ-026 Pipeline split:
- stage 1 registers mask generation plus per-segment encodes;
- stage 2 registers the final select, the increment and valid.

Verification
REQ-027 Each scenario uses Req[6:0] with all other bits 0, and checks outputs 2 cycles after the inputs are applied:
- Req[6:0] = 0100101, P_enc = 5 -> o_value 5, o_value_inc 6, valid 1.
- Req[6:0] = 0101101, P_enc = 4 -> 5.
- Req[6:0] = 0100111, P_enc = 2 -> 2.
- Req[6:0] = 1100101, P_enc = 1 -> 2.
- Req[6:0] = 1010101, P_enc = 0 -> 0.
REQ-028 Wrap-around: Req[6:0] = 0100101, P_enc = 6 -> o_value 0, o_value_inc 1, valid 1.
REQ-029 Req = 0, P_enc = 4 -> valid 0, o_value 0, o_value_inc 0.
REQ-030 Req all ones:
- P_enc = 500 -> 500/501; P_enc = 503 -> 503/504.
- P_enc = 511 -> o_value 511, o_value_inc 0.
REQ-031 Back-to-back: change the vector every cycle across the above cases -> each result appears exactly 2 cycles later, in order. Drive rst low mid-stream -> outputs clear immediately.
